// File: rtl/uiicmp_echo_reply_tx.sv
// ICMP echo reply transmitter: arbitrates for the IP tx path, then streams the
// 8-byte echo reply header followed by the payload drained from the echo FIFO.
module uiicmp_echo_reply_tx #(
    parameter logic [15:0] REQ_TIMEOUT     = 16'd4096,
    parameter logic [7:0]  ICMP_ECHO_REPLY = 8'h00
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_icmp_req_en,
    input  logic [15:0] I_icmp_req_id,
    input  logic [15:0] I_icmp_req_sq_num,
    input  logic [15:0] I_icmp_req_checksum,
    input  logic [9:0]  I_icmp_echo_data_len,
    output logic        O_echo_fifo_rd_en,
    input  logic [7:0]  I_echo_fifo_dout,
    output logic        O_icmp_tx_req,
    output logic [10:0] O_icmp_tx_len,
    input  logic        I_icmp_tx_ready,
    output logic        O_icmp_tx_valid,
    output logic [7:0]  O_icmp_tx_data,
    output logic        O_icmp_tx_last,
    output logic        O_busy,
    output logic        O_req_drop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HEADER,
        S_PAYLOAD,
        S_FLUSH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] id_q;
    logic [15:0] sq_q;
    logic [15:0] cksum_q;
    logic [9:0]  len_q;
    logic [10:0] tx_len_q;
    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [7:0]  hdr_byte;
    logic [7:0]  hdr_next;
    logic [7:0]  hdr_pick;
    logic [2:0]  hdr_idx;
    logic        drop_q;
    logic        timeout_hit;
    logic        rd_en;
    logic        last;
    logic        len_zero;
    logic [15:0] len_last;

    assign len_zero = (len_q == 10'd0);
    assign len_last = {6'd0, len_q} - 16'd1;
    assign hdr_idx  = cnt[2:0] + 3'd1;

    always_comb begin
        hdr_pick = 8'h00;
        case (hdr_idx)
            3'd0: hdr_pick = ICMP_ECHO_REPLY;
            3'd1: hdr_pick = 8'h00;
            3'd2: hdr_pick = cksum_q[15:8];
            3'd3: hdr_pick = cksum_q[7:0];
            3'd4: hdr_pick = id_q[15:8];
            3'd5: hdr_pick = id_q[7:0];
            3'd6: hdr_pick = sq_q[15:8];
            3'd7: hdr_pick = sq_q[7:0];
            default: hdr_pick = 8'h00;
        endcase
    end

    // One counter serves as request timeout, header index, payload and flush count.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        hdr_next    = hdr_byte;
        rd_en       = 1'b0;
        last        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (I_icmp_req_en) begin
                    state_next = S_REQ;
                    cnt_next   = 16'd0;
                end
            end
            S_REQ: begin
                if (I_icmp_tx_ready) begin
                    state_next = S_HEADER;
                    cnt_next   = 16'd0;
                    hdr_next   = ICMP_ECHO_REPLY;
                end else if (cnt == REQ_TIMEOUT - 16'd1) begin
                    timeout_hit = 1'b1;
                    cnt_next    = 16'd0;
                    state_next  = len_zero ? S_IDLE : S_FLUSH;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            S_HEADER: begin
                if (cnt[2:0] == 3'd7) begin
                    cnt_next = 16'd0;
                    if (len_zero) begin
                        last       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        rd_en      = 1'b1;
                        state_next = S_PAYLOAD;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                    hdr_next = hdr_pick;
                end
            end
            S_PAYLOAD: begin
                if (cnt == len_last) begin
                    last       = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    rd_en    = 1'b1;
                    cnt_next = cnt + 16'd1;
                end
            end
            S_FLUSH: begin
                rd_en = 1'b1;
                if (cnt == len_last) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state    <= S_IDLE;
            cnt      <= 16'd0;
            hdr_byte <= 8'h00;
            drop_q   <= 1'b0;
            id_q     <= 16'd0;
            sq_q     <= 16'd0;
            cksum_q  <= 16'd0;
            len_q    <= 10'd0;
            tx_len_q <= 11'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            hdr_byte <= hdr_next;
            drop_q   <= timeout_hit | (I_icmp_req_en & (state != S_IDLE));
            if (state == S_IDLE && I_icmp_req_en) begin
                id_q     <= I_icmp_req_id;
                sq_q     <= I_icmp_req_sq_num;
                cksum_q  <= I_icmp_req_checksum;
                len_q    <= I_icmp_echo_data_len;
                tx_len_q <= {1'b0, I_icmp_echo_data_len} + 11'd8;
            end
        end
    end

    // Payload bytes come straight from the FIFO output; header bytes are registered.
    assign O_icmp_tx_data    = (state == S_PAYLOAD) ? I_echo_fifo_dout :
                               (state == S_HEADER)  ? hdr_byte : 8'h00;
    assign O_icmp_tx_valid   = (state == S_HEADER) || (state == S_PAYLOAD);
    assign O_icmp_tx_last    = last;
    assign O_echo_fifo_rd_en = rd_en;
    assign O_icmp_tx_req     = (state == S_REQ);
    assign O_icmp_tx_len     = tx_len_q;
    assign O_busy            = (state != S_IDLE);
    assign O_req_drop        = drop_q;

endmodule

// File: tb/tb_uiicmp_echo_reply_tx.sv
// Bench for uiicmp_echo_reply_tx: table of request scenarios plus randomized
// requests, checked against a packet-level model of the expected reply.
module tb_uiicmp_echo_reply_tx;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_en = 1'b0;
    logic [15:0] req_id = 16'd0;
    logic [15:0] req_sq = 16'd0;
    logic [15:0] req_ck = 16'd0;
    logic [9:0]  data_len = 10'd0;
    logic        rd_en;
    logic [7:0]  fifo_dout = 8'h00;
    logic        tx_req;
    logic [10:0] tx_len;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        busy;
    logic        req_drop;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] fifo_q[$];

    typedef struct {
        logic [15:0] id;
        logic [15:0] sq;
        logic [15:0] ck;
        int          len;
        int          rdy;
        int          collide;
        int          exp_txlen;
        int          exp_valid;
        int          exp_rd;
        int          exp_drop;
        int          exp_req;
    } vec_t;

    uiicmp_echo_reply_tx #(
        .REQ_TIMEOUT(16'(TMO)),
        .ICMP_ECHO_REPLY(8'h00)
    ) dut (
        .I_clk(clk),
        .I_reset(reset),
        .I_icmp_req_en(req_en),
        .I_icmp_req_id(req_id),
        .I_icmp_req_sq_num(req_sq),
        .I_icmp_req_checksum(req_ck),
        .I_icmp_echo_data_len(data_len),
        .O_echo_fifo_rd_en(rd_en),
        .I_echo_fifo_dout(fifo_dout),
        .O_icmp_tx_req(tx_req),
        .O_icmp_tx_len(tx_len),
        .I_icmp_tx_ready(tx_ready),
        .O_icmp_tx_valid(tx_valid),
        .O_icmp_tx_data(tx_data),
        .O_icmp_tx_last(tx_last),
        .O_busy(busy),
        .O_req_drop(req_drop)
    );

    always #5 clk = ~clk;

    // Echo FIFO with one cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
            else fifo_dout <= 8'hEE;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [15:0] id, input logic [15:0] sq, input logic [15:0] ck,
                                   input int len, input int rdy, input int collide,
                                   input int exp_txlen, input int exp_valid, input int exp_rd,
                                   input int exp_drop, input int exp_req);
        vec_t v;
        v.id = id; v.sq = sq; v.ck = ck; v.len = len; v.rdy = rdy; v.collide = collide;
        v.exp_txlen = exp_txlen; v.exp_valid = exp_valid; v.exp_rd = exp_rd;
        v.exp_drop = exp_drop; v.exp_req = exp_req;
        return v;
    endfunction

    // Reference rules: a grant within the timeout window sends len+8 bytes, otherwise len bytes are flushed.
    function automatic vec_t modelExpect(input logic [15:0] id, input logic [15:0] sq, input logic [15:0] ck,
                                         input int len, input int rdy);
        bit sent;
        sent = (rdy >= 0) && (rdy < TMO);
        return mkVec(id, sq, ck, len, rdy, -1, len + 8, sent ? len + 8 : 0, len,
                     sent ? 0 : 1, sent ? rdy + 1 : TMO);
    endfunction

    task automatic resetDut();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        fifo_q.delete();
    endtask

    task automatic applyStimulus(input vec_t v, input bit fixed_pl, input int reset_at);
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int n_valid = 0, n_rd = 0, n_drop = 0, n_req = 0, n_last = 0;
        int last_idx = -1, first_vk = -1, last_vk = -1, first_rk = -1, mism = 0;
        int budget;
        bit done = 0;
        bit sent;
        sent = (v.rdy >= 0) && (v.rdy < TMO);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(v.ck[15:8]);
        exp_q.push_back(v.ck[7:0]);
        exp_q.push_back(v.id[15:8]);
        exp_q.push_back(v.id[7:0]);
        exp_q.push_back(v.sq[15:8]);
        exp_q.push_back(v.sq[7:0]);
        for (int i = 0; i < v.len; i++) begin
            b = fixed_pl ? 8'(8'h61 + i) : 8'($urandom);
            fifo_q.push_back(b);
            exp_q.push_back(b);
        end
        @(negedge clk);
        req_en   = 1'b1;
        req_id   = v.id;
        req_sq   = v.sq;
        req_ck   = v.ck;
        data_len = 10'(v.len);
        budget   = v.len + 200;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checkOutput("tx_len", int'(tx_len), v.exp_txlen);
                checkOutput("tx_req_after_accept", int'(tx_req), 1);
                req_id   = 16'($urandom);
                req_sq   = 16'($urandom);
                req_ck   = 16'($urandom);
                data_len = 10'($urandom);
            end
            if (tx_valid) begin
                if (first_vk < 0) first_vk = k;
                last_vk = k;
                if (n_valid >= exp_q.size() || tx_data !== exp_q[n_valid]) mism++;
                if (tx_last) begin
                    n_last++;
                    last_idx = n_valid;
                end
                n_valid++;
            end
            if (rd_en) begin
                n_rd++;
                if (first_rk < 0) first_rk = k;
            end
            n_drop += int'(req_drop);
            n_req  += int'(tx_req);
            if (!busy) done = 1;
            tx_ready = (k == v.rdy);
            req_en   = (k == v.collide);
            if (reset_at > 0 && n_valid == reset_at) begin
                reset    = 1'b1;
                tx_ready = 1'b0;
                req_en   = 1'b0;
                @(negedge clk);
                checkOutput("outputs_after_midreset",
                            int'({tx_valid, tx_data, tx_last, rd_en, tx_req, tx_len, busy, req_drop}), 0);
                reset = 1'b0;
                fifo_q.delete();
                return;
            end
        end
        tx_ready = 1'b0;
        req_en   = 1'b0;
        checkOutput("idle_within_budget", int'(done), 1);
        checkOutput("valid_count", n_valid, v.exp_valid);
        checkOutput("rd_en_count", n_rd, v.exp_rd);
        checkOutput("drop_count", n_drop, v.exp_drop);
        checkOutput("req_cycles", n_req, v.exp_req);
        checkOutput("last_count", n_last, sent ? 1 : 0);
        checkOutput("fifo_drained", fifo_q.size(), 0);
        if (sent) begin
            checkOutput("packet_bytes_wrong", mism, 0);
            checkOutput("last_position", last_idx, v.len + 7);
            checkOutput("contiguous_span", last_vk - first_vk + 1, n_valid);
            checkOutput("first_valid_latency", first_vk, v.rdy + 1);
            if (v.len > 0) checkOutput("rd_start_at_byte7", first_rk, first_vk + 7);
        end
        if (!done) resetDut();
    endtask

    initial begin
        vec_t tbl[8];
        vec_t rv;
        int   rlen, rrdy;
        tbl[0] = mkVec(16'h0001, 16'h0007, 16'hABCD, 4,    3,  -1,  12,   12,   4,    0, 4);
        tbl[1] = mkVec(16'h1234, 16'h5678, 16'h9ABC, 0,    2,  -1,  8,    8,    0,    0, 3);
        tbl[2] = mkVec(16'hBEEF, 16'h0100, 16'h0F0F, 32,   -1, -1,  40,   0,    32,   1, 16);
        tbl[3] = mkVec(16'hCAFE, 16'h0002, 16'h1111, 5,    15, -1,  13,   13,   5,    0, 16);
        tbl[4] = mkVec(16'h0A0B, 16'h0C0D, 16'h2222, 0,    -1, -1,  8,    0,    0,    1, 16);
        tbl[5] = mkVec(16'hFFFF, 16'hFFFE, 16'h3333, 1023, 0,  300, 1031, 1031, 1023, 1, 1);
        tbl[6] = mkVec(16'h4444, 16'h5555, 16'h6666, 1,    0,  -1,  9,    9,    1,    0, 1);
        tbl[7] = mkVec(16'h7777, 16'h8888, 16'h9999, 2,    1,  -1,  10,   10,   2,    0, 2);

        repeat (2) @(negedge clk);
        checkOutput("outputs_in_reset",
                    int'({tx_valid, tx_data, tx_last, rd_en, tx_req, tx_len, busy, req_drop}), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", int'({busy, tx_req, tx_valid}), 0);

        for (int i = 0; i < 8; i++) applyStimulus(tbl[i], 1'b1, 0);

        $display("[TB] reset during payload");
        applyStimulus(mkVec(16'h0102, 16'h0304, 16'h0506, 40, 2, -1, 48, 48, 40, 0, 3), 1'b0, 20);
        applyStimulus(mkVec(16'h0001, 16'h0007, 16'hABCD, 4, 3, -1, 12, 12, 4, 0, 4), 1'b1, 0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 24; i++) begin
            rlen = int'($urandom_range(0, 48));
            rrdy = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
            rv = modelExpect(16'($urandom), 16'($urandom), 16'($urandom), rlen, rrdy);
            applyStimulus(rv, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uiicmp_echo_reply_tx.md
Name: uiicmp_echo_reply_tx

Overview:
- Transmit side of ICMP ping handling. Takes the echo-request summary from the ICMP receive parser: req_en pulse, identifier, sequence number, reply checksum and payload length.
- Takes the echoed payload from the icmp_echo_data_fifo (first-word-fall-through off, 1-cycle read latency).
- Arbitrates for the IP transmit path, then streams a complete ICMP echo reply byte-by-byte into ip_arp_tx: 8-byte header followed by the payload.

Parameters:
- REQ_TIMEOUT, 16'd4096, cycles to wait for I_icmp_tx_ready before abandoning a reply.
- ICMP_ECHO_REPLY, 8'h00, value sent in the type field.

Ports:
- I_clk  in  1  clock
- I_reset  in  1  synchronous active-high reset
- I_icmp_req_en  in  1  one-cycle pulse: echo request received, reply wanted
- I_icmp_req_id  in  16  identifier to echo
- I_icmp_req_sq_num  in  16  sequence number to echo
- I_icmp_req_checksum  in  16  final reply checksum, sent unmodified
- I_icmp_echo_data_len  in  10  payload byte count held in FIFO
- O_echo_fifo_rd_en  out  1  FIFO read strobe
- I_echo_fifo_dout  in  8  FIFO data, valid the cycle after rd_en
- O_icmp_tx_req  out  1  request IP tx path, level
- O_icmp_tx_len  out  11  ICMP length = data_len + 8
- I_icmp_tx_ready  in  1  IP tx grants; streaming starts next cycle
- O_icmp_tx_valid  out  1  byte valid
- O_icmp_tx_data  out  8  byte
- O_icmp_tx_last  out  1  final byte of packet
- O_busy  out  1  high in any state except IDLE
- O_req_drop  out  1  one-cycle pulse: request ignored or timed out

Behaviour:
- Reset (sync, highest priority, also mid-packet): state IDLE, all outputs 0, latched fields 0, counters 0. A reply in flight is truncated without O_icmp_tx_last. FIFO contents are not flushed by this block.
- States: IDLE, REQ, HEADER, PAYLOAD, FLUSH.
- IDLE:
  - On I_icmp_req_en, latch id, sq_num, checksum, len.
  - Next cycle: REQ, O_icmp_tx_req=1, O_icmp_tx_len=len+8, timeout counter=0.
- REQ:
  - Hold O_icmp_tx_req.
  - If I_icmp_tx_ready: drop req, go HEADER next cycle.
  - Else, when the counter reaches REQ_TIMEOUT-1: go FLUSH and pulse O_req_drop.
  - Ready and timeout in the same cycle: ready wins.
- HEADER: 8 cycles, O_icmp_tx_valid=1, bytes in order:
  - ICMP_ECHO_REPLY, 8'h00
  - checksum[15:8], checksum[7:0]
  - id[15:8], id[7:0]
  - sq[15:8], sq[7:0]
  - Header bytes are registered outputs.
- HEADER to PAYLOAD (len>0):
  - O_echo_fifo_rd_en asserts on the cycle header byte 7 is presented, and stays high for exactly len consecutive cycles.
  - In PAYLOAD, O_icmp_tx_data = I_echo_fifo_dout (output mux, no extra register), so payload byte k appears 1 cycle after its read.
  - Payload counter runs 0..len-1; O_icmp_tx_last accompanies payload byte len-1; then IDLE.
- len==0: no FIFO reads; O_icmp_tx_last accompanies header byte 7; HEADER goes straight to IDLE.
- Total valid cycles per packet = len+8, contiguous, no gaps. Downstream has no backpressure once granted.
- FLUSH: discard the latched len bytes from the FIFO, rd_en high for len cycles, no tx_valid; then IDLE. len==0 goes directly to IDLE.
- I_icmp_req_en while O_busy: ignored and O_req_drop pulses.
  - The FIFO then holds extra data; the upstream parser must not issue back-to-back requests. Dropped-request data is the parser's responsibility.
- Length arithmetic: 11-bit, max 1023+8=1031, no overflow.
- Inputs other than req_en are sampled only on the accepted req_en cycle.

Test Plan:
- Basic ping: req_en with id=16'h0001, sq=16'h0007, cksum=16'hABCD, len=4; FIFO holds 61 62 63 64; ready 3 cycles after req. Required: tx_len=12; stream 00 00 AB CD 00 01 00 07 61 62 63 64, 12 contiguous valids; last on 8'h64; rd_en high on exactly 4 cycles, starting with byte 7.
- len=0: header only, last on 8th byte (sq LSB), rd_en never high.
- Timeout with REQ_TIMEOUT=16, len=32, ready held low: req high 16 cycles, one O_req_drop pulse, 32 rd_en cycles, no tx_valid, then IDLE. Ready and timeout arriving together: packet is sent.
- Busy collision: second req_en during payload of a len=1023 reply: O_req_drop pulses once; first packet is 1031 bytes, unaffected.
- Reset mid-payload at byte 20: all outputs 0 next cycle. A fresh request afterwards produces a correct packet.
- Back-to-back: two requests separated by ≥1 idle cycle after last: both packets correct, second header starts only after its own ready.
